// File: rtl/cpu_data_path_pkg.sv
// Shared constants for the CPU datapath: width, ALU op codes,
// bus select codes and condition-code bit positions.
package cpu_pkg;

  localparam int WIDTH = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_INC = 3'b101;
  localparam logic [2:0] ALU_DEC = 3'b110;
  localparam logic [2:0] ALU_NOT = 3'b111;

  localparam logic [1:0] BUS1_PC   = 2'b00;
  localparam logic [1:0] BUS1_A    = 2'b01;
  localparam logic [1:0] BUS1_B    = 2'b10;
  localparam logic [1:0] BUS1_ZERO = 2'b11;

  localparam logic [1:0] BUS2_ALU  = 2'b00;
  localparam logic [1:0] BUS2_BUS1 = 2'b01;
  localparam logic [1:0] BUS2_MEM  = 2'b10;
  localparam logic [1:0] BUS2_ZERO = 2'b11;

  localparam int CCR_C = 0;
  localparam int CCR_Z = 1;
  localparam int CCR_N = 2;
  localparam int CCR_V = 3;

endpackage

// File: rtl/cpu_data_path_if.sv
// Control-unit / memory side of the datapath: load strobes, selects,
// memory read/write data and the feedback values to the control unit.
interface cpu_data_path_if #(parameter int WIDTH = 8);

  logic             IR_Load;
  logic             MAR_Load;
  logic             PC_Load;
  logic             PC_Inc;
  logic             A_Load;
  logic             B_Load;
  logic             CCR_Load;
  logic [2:0]       ALU_Sel;
  logic [1:0]       Bus1_Sel;
  logic [1:0]       Bus2_Sel;
  logic [WIDTH-1:0] from_memory;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] to_memory;
  logic [WIDTH-1:0] IR;
  logic [3:0]       CCR_Result;

  modport master (
    output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
    output ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
    input  address, to_memory, IR, CCR_Result
  );

  modport slave (
    input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
    input  ALU_Sel, Bus1_Sel, Bus2_Sel, from_memory,
    output address, to_memory, IR, CCR_Result
  );

endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU. X comes from Bus1, Y from the B register.
// Flags are returned in CCR bit order ({V,N,Z,C}).
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int W = cpu_pkg::WIDTH
) (
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic [2:0]   ALU_Sel,
  output logic [W-1:0] R,
  output logic [3:0]   NZVC
);

  logic [W:0]   sum;
  logic [W-1:0] opnd;
  logic         c_flag;
  logic         v_flag;

  // Result and carry/overflow; INC/DEC reuse the add/sub path with operand 1.
  always_comb begin
    sum    = '0;
    opnd   = Y;
    R      = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (ALU_Sel)
      ALU_ADD, ALU_INC: begin
        if (ALU_Sel == ALU_INC) opnd = {{(W-1){1'b0}}, 1'b1};
        sum    = {1'b0, X} + {1'b0, opnd};
        R      = sum[W-1:0];
        c_flag = sum[W];
        v_flag = (X[W-1] == opnd[W-1]) && (R[W-1] != X[W-1]);
      end
      ALU_SUB, ALU_DEC: begin
        if (ALU_Sel == ALU_DEC) opnd = {{(W-1){1'b0}}, 1'b1};
        sum    = {1'b0, X} - {1'b0, opnd};
        R      = sum[W-1:0];
        c_flag = sum[W];  // borrow: set exactly when X < opnd
        v_flag = (X[W-1] != opnd[W-1]) && (R[W-1] != X[W-1]);
      end
      ALU_AND: R = X & Y;
      ALU_OR:  R = X | Y;
      ALU_XOR: R = X ^ Y;
      default: R = ~X;
    endcase
  end

  // Pack flags into CCR bit positions.
  always_comb begin
    NZVC        = '0;
    NZVC[CCR_C] = c_flag;
    NZVC[CCR_Z] = (R == '0);
    NZVC[CCR_N] = R[W-1];
    NZVC[CCR_V] = v_flag;
  end

endmodule

// File: rtl/cpu_data_path.sv
// CPU datapath: IR, MAR, PC, A, B, CCR, the two bus muxes and the ALU.
// Optional debug mirrors of A/B/PC/MAR are enabled with DATA_PATH_DEBUG_EN.
module cpu_data_path
  import cpu_pkg::*;
#(
  parameter int         WIDTH    = cpu_pkg::WIDTH,
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic             Clk,
  input  logic             Reset,
  cpu_data_path_if.slave   bus
`ifdef DATA_PATH_DEBUG_EN
  ,
  output logic [WIDTH-1:0] dbg_A,
  output logic [WIDTH-1:0] dbg_B,
  output logic [WIDTH-1:0] dbg_PC,
  output logic [WIDTH-1:0] dbg_MAR
`endif
);

  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mar_q, mar_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ccr_q, ccr_d;
  logic [WIDTH-1:0] bus1;
  logic [WIDTH-1:0] bus2;
  logic [WIDTH-1:0] alu_r;
  logic [3:0]       alu_nzvc;

  cpu_alu #(.W(WIDTH)) u_alu (
    .X       (bus1),
    .Y       (b_q),
    .ALU_Sel (bus.ALU_Sel),
    .R       (alu_r),
    .NZVC    (alu_nzvc)
  );

  // Bus1 feeds the ALU X operand and the memory write data.
  always_comb begin
    case (bus.Bus1_Sel)
      BUS1_PC: bus1 = pc_q;
      BUS1_A:  bus1 = a_q;
      BUS1_B:  bus1 = b_q;
      default: bus1 = '0;
    endcase
  end

  // Bus2 is the common source for every register load.
  always_comb begin
    case (bus.Bus2_Sel)
      BUS2_ALU:  bus2 = alu_r;
      BUS2_BUS1: bus2 = bus1;
      BUS2_MEM:  bus2 = bus.from_memory;
      default:   bus2 = '0;
    endcase
  end

  // Next-state for each register; PC load takes priority over increment.
  always_comb begin
    ir_d  = bus.IR_Load  ? bus2 : ir_q;
    mar_d = bus.MAR_Load ? bus2 : mar_q;
    a_d   = bus.A_Load   ? bus2 : a_q;
    b_d   = bus.B_Load   ? bus2 : b_q;
    ccr_d = bus.CCR_Load ? alu_nzvc : ccr_q;
    if (bus.PC_Load)     pc_d = bus2;
    else if (bus.PC_Inc) pc_d = pc_q + 1'b1;
    else                 pc_d = pc_q;
  end

  // Register bank with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ir_q  <= '0;
      mar_q <= '0;
      pc_q  <= PC_RESET;
      a_q   <= '0;
      b_q   <= '0;
      ccr_q <= '0;
    end else begin
      ir_q  <= ir_d;
      mar_q <= mar_d;
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      ccr_q <= ccr_d;
    end
  end

  assign bus.address    = mar_q;
  assign bus.to_memory  = bus1;
  assign bus.IR         = ir_q;
  assign bus.CCR_Result = ccr_q;

`ifdef DATA_PATH_DEBUG_EN
  assign dbg_A   = a_q;
  assign dbg_B   = b_q;
  assign dbg_PC  = pc_q;
  assign dbg_MAR = mar_q;
`endif

endmodule

// File: doc/cpu_data_path.md
Name: cpu_data_path

Overview:
- 8-bit datapath driven by the control unit's load, select and ALU-select strobes.
- Holds IR, MAR, PC, A, B and CCR, the two internal buses and the ALU.
- Produces IR and CCR_Result for the control unit and the address/write-data interface to memory.
- Sits directly downstream of the control unit and closes its feedback loop.

Parameters:
- WIDTH, 8: data/address width. Only 8 is supported; the package constants assume 8.
- PC_RESET, 8'h00: PC value after reset.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- IR_Load  in  1  IR <= Bus2.
- MAR_Load  in  1  MAR <= Bus2.
- PC_Load  in  1  PC <= Bus2.
- PC_Inc  in  1  PC <= PC+1.
- A_Load  in  1  A <= Bus2.
- B_Load  in  1  B <= Bus2.
- CCR_Load  in  1  CCR <= NZVC from the ALU.
- ALU_Sel  in  3  ALU operation select.
- Bus1_Sel  in  2  00 PC, 01 A, 10 B, 11 8'h00.
- Bus2_Sel  in  2  00 ALU result, 01 Bus1, 10 from_memory, 11 8'h00.
- from_memory  in  WIDTH  read data from memory.
- address  out  WIDTH  = MAR.
- to_memory  out  WIDTH  = Bus1.
- IR  out  WIDTH  instruction register.
- CCR_Result  out  4  {V,N,Z,C}: bit0 C, bit1 Z, bit2 N, bit3 V.

Behaviour:
- Single clock Clk. Reset is synchronous, active-low: sampled on the Clk rising edge while Reset==0.
- Reset values: IR=00, MAR=00, PC=PC_RESET, A=00, B=00, CCR=0000. Reset overrides every load strobe in the same cycle.
- Bus1 and Bus2 are combinational muxes. address, to_memory, IR and CCR_Result are register outputs or bus copies, with no added latency.
- Every load takes effect at the next rising edge and is visible one cycle after the strobe.
- PC: PC_Load has priority over PC_Inc when both are high. PC increment wraps FF->00.
- Several loads in one cycle are legal. All loaded registers capture the same Bus2 value.
- ALU: operand X=Bus1, Y=B register, result R is 8 bits. Codes:
  - 000 ADD X+Y.
  - 001 SUB X-Y.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 INC X+1.
  - 110 DEC X-1.
  - 111 NOT ~X.
- Flags, computed combinationally and latched only on CCR_Load:
  - N=R[7]; Z=(R==0).
  - ADD/INC: C = carry out of bit 7; V = operands of the same sign and R sign different.
  - SUB/DEC: C = borrow (X<subtrahend, unsigned); V = operands of different sign and R sign differs from X.
  - AND/OR/XOR/NOT: V=0, C=0.
- CCR_Load with Bus2_Sel!=00 still latches the flags of the current ALU output. Bus2 routing does not affect the flags.
- Reset asserted mid-instruction: all registers return to their reset values on that edge. Outputs are valid the next cycle.

Optional Feature:
- Macro: DATA_PATH_DEBUG_EN.
- Defined: adds output ports dbg_A, dbg_B, dbg_PC, dbg_MAR (WIDTH each), directly mirroring the registers.
- Undefined: those ports do not exist. Functional behaviour is identical either way.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU_Sel code constants (ALU_ADD..ALU_NOT).
  - Bus1/Bus2 select constants.
  - CCR bit-index constants (CCR_C=0, CCR_Z=1, CCR_N=2, CCR_V=3).
  - WIDTH default.
- One sub-module, cpu_alu: combinational. Inputs X, Y, ALU_Sel; outputs R and NZVC.
- Registers and bus muxes stay in cpu_data_path.

Test Plan:
- Reset held low for 2 edges with all loads high -> IR=00, PC=00, A=B=00, CCR_Result=0000. Release, pulse PC_Inc 3 cycles -> PC=03, address unaffected.
- Bus2_Sel=10, from_memory=86, IR_Load=1 -> IR=86 next cycle. Then from_memory=2A, A_Load=1 -> A=2A.
- A=7F, B=01, Bus1_Sel=01, ALU_Sel=000, Bus2_Sel=00, A_Load=1, CCR_Load=1 -> A=80, CCR_Result=1100 (V=1, N=1).
- A=05, B=05, ALU_Sel=001, CCR_Load=1 -> R=00, CCR_Result=0010. Then A=03, B=05, SUB -> R=FE, CCR_Result=0101 (N=1, C=1).
- PC=FF with PC_Inc=1 -> PC=00. PC_Load=1 with PC_Inc=1 and Bus2=from_memory=40 -> PC=40 (load wins).
- Bus1_Sel=10, B=3C, MAR_Load via Bus2_Sel=10, from_memory=E0 -> address=E0, to_memory=3C. Bus1_Sel=11 -> to_memory=00.
